// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M/RV64M multiply/divide execution unit for the EX stage.
// The multiply latency is set by MUL_STAGES. DIV, DIVU, REM and REMU use an iterative
// radix-2 restoring divider that produces one quotient bit per cycle.
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   i_req           M-extension op present in EX; held with opcode/a/b while o_stall=1
//   i_flush         kills the in-flight op
//   i_opcode        funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   i_a, i_b        rs1, rs2
//   o_o             registered rd result; holds the last completed result
//   o_done          one-cycle pulse in the completion cycle
//   o_stall         combinational pipeline hold
module muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 2,
  parameter bit          DIV_EN     = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic            i_flush,
  input  logic [2:0]      i_opcode,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_o,
  output logic            o_done,
  output logic            o_stall
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam int unsigned PW = 2 * XLEN + 2;
  localparam int unsigned RW = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a, r_b, r_o, r_rem, r_quo, r_div;
  logic [CW-1:0]   r_cnt;
  logic            r_done, r_neg_q, r_neg_r, r_is_rem;

  logic            w_idle, w_accept, w_wr, w_done_nxt, w_stall;
  logic [XLEN-1:0] w_res;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = i_req & ~i_flush & w_idle;

  // Multiplier operands: the live inputs in the accept cycle (for MUL_STAGES=1), latched copies after.
  logic [2:0]             w_op;
  logic [XLEN-1:0]        w_ma, w_mb, w_mul_res;
  logic [XLEN:0]          w_a_ext, w_b_ext;
  logic signed [PW-1:0]   w_pa, w_pb;
  logic [RW-1:0]          w_prod;

  assign w_op      = w_idle ? i_opcode : r_op;
  assign w_ma      = w_idle ? i_a : r_a;
  assign w_mb      = w_idle ? i_b : r_b;
  assign w_a_ext   = {w_ma[XLEN-1] & (w_op != 3'b011), w_ma};
  assign w_b_ext   = {w_mb[XLEN-1] & ~((w_op == 3'b010) | (w_op == 3'b011)), w_mb};
  assign w_pa      = PW'($signed(w_a_ext));
  assign w_pb      = PW'($signed(w_b_ext));
  // The two top product bits never reach the result, so only 2*XLEN bits are kept.
  assign w_prod    = RW'(w_pa * w_pb);
  assign w_mul_res = (w_op == 3'b000) ? w_prod[XLEN-1:0] : w_prod[RW-1:XLEN];

  // Divider setup from the live inputs in the accept cycle.
  logic            w_signed, w_sa, w_sb, w_b_zero, w_ovf, w_fast;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_min, w_fast_res;

  assign w_signed = ~i_opcode[0];
  assign w_sa     = w_signed & i_a[XLEN-1];
  assign w_sb     = w_signed & i_b[XLEN-1];
  assign w_abs_a  = w_sa ? (XLEN'(0) - i_a) : i_a;
  assign w_abs_b  = w_sb ? (XLEN'(0) - i_b) : i_b;
  assign w_min    = {1'b1, {(XLEN-1){1'b0}}};
  assign w_b_zero = (i_b == '0);
  assign w_ovf    = w_signed & (i_a == w_min) & (i_b == '1);
  assign w_fast   = ~DIV_EN | w_b_zero | w_ovf;

  always_comb begin
    w_fast_res = '0;
    if (!DIV_EN)       w_fast_res = '0;
    else if (w_b_zero) w_fast_res = i_opcode[1] ? i_a : '1;
    else               w_fast_res = i_opcode[1] ? '0 : w_min;
  end

  // One restoring shift-subtract step; the partial remainder is always below the divisor.
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_qbit;
  logic [XLEN-1:0] w_rem_nxt, w_quo_nxt, w_div_res;

  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_div};
  assign w_qbit    = ~w_diff[XLEN];
  assign w_rem_nxt = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_qbit};
  assign w_div_res = r_is_rem ? (r_neg_r ? (XLEN'(0) - w_rem_nxt) : w_rem_nxt)
                              : (r_neg_q ? (XLEN'(0) - w_quo_nxt) : w_quo_nxt);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and result write; o is written one edge before the done cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_res       = '0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (i_opcode[2]) begin
            w_state_nxt = S_DIV;
            if (w_fast) begin
              w_wr       = 1'b1;
              w_res      = w_fast_res;
              w_done_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = S_MUL;
            if (MUL_STAGES == 1) begin
              w_wr       = 1'b1;
              w_res      = w_mul_res;
              w_done_nxt = 1'b1;
            end
          end
        end
      end
      S_MUL: begin
        if (r_done || i_flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CW'(MUL_STAGES - 1)) begin
          w_wr       = 1'b1;
          w_res      = w_mul_res;
          w_done_nxt = 1'b1;
        end
      end
      S_DIV: begin
        if (r_done || i_flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CW'(XLEN)) begin
          w_wr       = 1'b1;
          w_res      = w_div_res;
          w_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_stall = rst_n & (w_accept | (~w_idle & ~r_done & ~i_flush));
  end

  // Operand latch, iteration counter and divider datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_o      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_wr) r_o <= w_res;
      if (w_accept) begin
        r_op     <= i_opcode;
        r_a      <= i_a;
        r_b      <= i_b;
        r_cnt    <= CW'(1);
        r_rem    <= '0;
        r_quo    <= w_abs_a;
        r_div    <= w_abs_b;
        r_neg_q  <= w_sa ^ w_sb;
        r_neg_r  <= w_sa;
        r_is_rem <= i_opcode[1];
      end else if (!w_idle) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_state == S_DIV) begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
        end
      end
    end
  end

  assign o_o     = r_o;
  assign o_done  = r_done;
  assign o_stall = w_stall;

endmodule
